// File: rtl/avalon_master_bridge.sv
// Avalon-MM initiator: valid/ready commands to single-word transfers, in-order read FIFO.
// Define AVALON_MASTER_WAITREQUEST_EN to honor waitrequest; otherwise every transfer takes one cycle.
module avalon_master_bridge #(
   parameter int ADDRESSWIDTH = 4,
   parameter int MAXPENDING   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDRESSWIDTH-1:0] cmd_address,
   input  logic [31:0]             cmd_data,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [31:0]             rsp_data,
   output logic                    read,
   output logic                    write,
   output logic [ADDRESSWIDTH-1:0] address,
   output logic [31:0]             data_out,
   input  logic                    waitrequest,
   input  logic                    read_valid,
   input  logic [31:0]             data_in,
   output logic                    protocol_error
);
   localparam int CW = $clog2(MAXPENDING) + 1;
   localparam int PW = $clog2(MAXPENDING);

   logic [CW-1:0] credits;
   logic [CW-1:0] outstanding;
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [31:0]   fifo_mem [MAXPENDING];
   logic          stall;
   logic          busy;
   logic          complete;
   logic          accept;
   logic          rsp_pop;
   logic          push;
   logic          fifo_empty;

`ifdef AVALON_MASTER_WAITREQUEST_EN
   assign stall = waitrequest;
`else
   logic unused_waitrequest;
   assign unused_waitrequest = waitrequest;
   assign stall = 1'b0;
`endif

   assign busy       = read | write;
   assign complete   = busy && !stall;
   assign cmd_ready  = !reset && (!busy || complete) &&
                       (credits < CW'(MAXPENDING));
   assign accept     = cmd_valid && cmd_ready;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign rsp_valid  = !fifo_empty;
   assign rsp_pop    = rsp_valid && rsp_ready;
   assign push       = read_valid && (outstanding != '0);
   // Masked so the head reads as zero while empty, including right after reset.
   assign rsp_data   = fifo_empty ? '0 : fifo_mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read     <= 1'b0;
         write    <= 1'b0;
         address  <= '0;
         data_out <= '0;
      end else if (accept) begin
         read     <= !cmd_write;
         write    <= cmd_write;
         address  <= cmd_address;
         data_out <= cmd_data;
      end else if (complete) begin
         read  <= 1'b0;
         write <= 1'b0;
      end
   end

   // Credits cover reads from acceptance until their response is popped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credits <= '0;
      end else begin
         unique case ({accept && !cmd_write, rsp_pop})
            2'b10:   credits <= credits + 1'b1;
            2'b01:   credits <= credits - 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         unique case ({complete && read, push})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         protocol_error <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (rsp_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (read_valid && (outstanding == '0))
            protocol_error <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr[PW-1:0]] <= data_in;
   end
endmodule

// File: tb/tb_avalon_master_bridge.sv
// Directed bench for avalon_master_bridge with a fixed-latency register slave.
// The stall scenario runs only when AVALON_MASTER_WAITREQUEST_EN is defined.
module tb_avalon_master_bridge;
   localparam int AW = 4;

   logic          clk;
   logic          reset       = 1'b1;
   logic          cmd_valid   = 1'b0;
   logic          cmd_write   = 1'b0;
   logic [AW-1:0] cmd_address = '0;
   logic [31:0]   cmd_data    = '0;
   logic          rsp_ready   = 1'b0;
   logic          waitrequest = 1'b0;
   logic          cmd_ready;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic          read;
   logic          write;
   logic [AW-1:0] address;
   logic [31:0]   data_out;
   logic          read_valid;
   logic [31:0]   data_in;
   logic          protocol_error;

   int          vectors  = 0;
   int          errors   = 0;
   int          lat      = 2;
   logic        force_rv = 1'b0;
   logic [31:0] force_d  = '0;
   logic [31:0] smem    [16];
   logic [31:0] exp_mem [16];
   logic        pv      [8];
   logic [31:0] pd      [8];

   avalon_master_bridge #(.ADDRESSWIDTH(AW), .MAXPENDING(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_address(cmd_address),
      .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .read(read), .write(write), .address(address),
      .data_out(data_out), .waitrequest(waitrequest),
      .read_valid(read_valid), .data_in(data_in),
      .protocol_error(protocol_error)
   );

   always begin
      clk = 1'b0; #5;
      clk = 1'b1; #5;
   end

   function automatic logic [31:0] init_word(int a);
      return 32'hD00D_0000 + 32'(a * 257);
   endfunction

   // Register slave: read data returns exactly lat cycles after the bus cycle.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) smem[i] <= init_word(i);
         for (int i = 0; i < 8; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
         end
      end else begin
         pv[0] <= read && !waitrequest;
         pd[0] <= smem[address];
         for (int i = 1; i < 8; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         if (write && !waitrequest) smem[address] <= data_out;
      end
   end

   assign read_valid = force_rv | pv[lat-1];
   assign data_in    = force_rv ? force_d : pd[lat-1];

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
      vectors++;
      if ({rsp_valid, read, write, protocol_error} !== 4'b0000) begin
         errors++; $display("FAIL rst_flags got %b want 0000", {rsp_valid, read, write, protocol_error});
      end
      vectors++;
      if (rsp_data !== 32'h0 || data_out !== 32'h0 || address !== 4'h0) begin
         errors++; $display("FAIL rst_data got %h/%h/%h want 0", rsp_data, data_out, address);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", cmd_ready); end
   endtask

   task automatic test_write_read();
      int bad = 0;
      lat = 2;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 4'd3; cmd_data = 32'hA5A5_0001;
      #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      exp_mem[3] = 32'hA5A5_0001;
      vectors++;
      if ({write, read} !== 2'b10 || address !== 4'd3 || data_out !== 32'hA5A5_0001) begin
         errors++; $display("FAIL wr_bus got w%b r%b a%h d%h want w1 r0 a3 dA5A50001", write, read, address, data_out);
      end
      @(negedge clk);
      vectors++;
      if (write !== 1'b0) begin errors++; $display("FAIL wr_len got %b want 0", write); end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'd3;
      #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready got %b want 1", cmd_ready); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (rsp_valid !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin errors++; $display("FAIL rd_early got %0d early cycles want 0", bad); end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A5_0001) begin
         errors++; $display("FAIL rd_latency got v%b %h want v1 a5a50001", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      vectors++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pop got %b want 0", rsp_valid); end
   endtask

   task automatic test_credit();
      int acc = 0;
      int n = 0;
      lat = 1;
      rsp_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         cmd_valid = (acc < 6); cmd_write = 1'b0; cmd_address = AW'(8 + acc);
         #1;
         if (cmd_valid && cmd_ready) acc++;
      end
      @(negedge clk);
      #1;
      vectors++;
      if (acc != 4 || cmd_ready !== 1'b0) begin
         errors++; $display("FAIL credit_limit got %0d rdy%b want 4 rdy0", acc, cmd_ready);
      end
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_mem[8]) begin
         errors++; $display("FAIL credit_head got v%b %h want v1 %h", rsp_valid, rsp_data, exp_mem[8]);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL credit_return got %b want 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      vectors++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL credit_refull got %b want 0", cmd_ready); end
      rsp_ready = 1'b1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         if (rsp_valid) begin
            vectors++;
            if (rsp_data !== exp_mem[9+n]) begin
               errors++; $display("FAIL credit_order[%0d] got %h want %h", n, rsp_data, exp_mem[9+n]);
            end
            n++;
         end
         @(negedge clk);
      end
      vectors++;
      if (n != 4) begin errors++; $display("FAIL credit_count got %0d want 4", n); end
   endtask

   task automatic test_stream();
      int n = 0;
      int bub = 0;
      int badrd = 0;
      lat = 1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         cmd_valid = (c < 16); cmd_write = 1'b0; cmd_address = AW'(c);
         #1;
         if (c < 16 && cmd_ready !== 1'b1) bub++;
         if (c >= 1 && c <= 16 && (read !== 1'b1 || address !== AW'(c - 1))) badrd++;
         if (rsp_valid) begin
            vectors++;
            if (n >= 16 || rsp_data !== exp_mem[n]) begin
               errors++; $display("FAIL stream_data[%0d] got %h want %h", n, rsp_data, exp_mem[n % 16]);
            end
            n++;
         end
      end
      cmd_valid = 1'b0;
      vectors++;
      if (bub != 0) begin errors++; $display("FAIL stream_bubbles got %0d want 0", bub); end
      vectors++;
      if (badrd != 0) begin errors++; $display("FAIL stream_reads got %0d bad cycles want 0", badrd); end
      vectors++;
      if (n != 16) begin errors++; $display("FAIL stream_count got %0d want 16", n); end
      rsp_ready = 1'b0;
   endtask

`ifdef AVALON_MASTER_WAITREQUEST_EN
   task automatic test_stall();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 4'd7; cmd_data = 32'hC0DE_0007;
      @(negedge clk);
      cmd_address = 4'd5; cmd_data = 32'h5555_0005;
      for (int s = 0; s < 4; s++) begin
         if (s > 0) @(negedge clk);
         waitrequest = (s < 3);
         #1;
         vectors++;
         if (write !== 1'b1 || address !== 4'd7 || data_out !== 32'hC0DE_0007) begin
            errors++; $display("FAIL stall_hold[%0d] got w%b a%h d%h want w1 a7 dc0de0007", s, write, address, data_out);
         end
         vectors++;
         if (cmd_ready !== (s == 3)) begin
            errors++; $display("FAIL stall_ready[%0d] got %b want %b", s, cmd_ready, s == 3);
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      waitrequest = 1'b0;
      exp_mem[7] = 32'hC0DE_0007;
      exp_mem[5] = 32'h5555_0005;
      vectors++;
      if (write !== 1'b1 || address !== 4'd5 || data_out !== 32'h5555_0005) begin
         errors++; $display("FAIL stall_next got w%b a%h d%h want w1 a5 d55550005", write, address, data_out);
      end
      @(negedge clk);
      vectors++;
      if (write !== 1'b0) begin errors++; $display("FAIL stall_end got %b want 0", write); end
   endtask
`endif

   task automatic test_spurious();
      @(negedge clk);
      rsp_ready = 1'b0;
      force_rv = 1'b1; force_d = 32'h0000_1234;
      #1;
      vectors++;
      if (protocol_error !== 1'b0) begin errors++; $display("FAIL spur_pre got %b want 0", protocol_error); end
      @(negedge clk);
      force_rv = 1'b0;
      vectors++;
      if (protocol_error !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL spur_set got pe%b v%b want pe1 v0", protocol_error, rsp_valid);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (protocol_error !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL spur_sticky got pe%b v%b want pe1 v0", protocol_error, rsp_valid);
      end
   endtask

   task automatic test_reset_flight();
      logic [AW-1:0] adr [3];
      int t = 0;
      adr[0] = 4'd1; adr[1] = 4'd2; adr[2] = 4'd4;
      lat = 4;
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = adr[c];
         #1;
         vectors++;
         if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rf_issue[%0d] got %b want 1", c, cmd_ready); end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      while (rsp_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_mem[1]) begin
         errors++; $display("FAIL rf_first got v%b %h want v1 %h", rsp_valid, rsp_data, exp_mem[1]);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({cmd_ready, rsp_valid, read, write, protocol_error} !== 5'b00000) begin
         errors++; $display("FAIL rf_flags got %b want 00000", {cmd_ready, rsp_valid, read, write, protocol_error});
      end
      vectors++;
      if (rsp_data !== 32'h0 || data_out !== 32'h0 || address !== 4'h0) begin
         errors++; $display("FAIL rf_data got %h/%h/%h want 0", rsp_data, data_out, address);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      force_rv = 1'b1; force_d = 32'h0000_BEEF;
      @(negedge clk);
      force_rv = 1'b0;
      vectors++;
      if (protocol_error !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rf_late got pe%b v%b want pe1 v0", protocol_error, rsp_valid);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
      test_reset();
      test_write_read();
      test_credit();
      test_stream();
`ifdef AVALON_MASTER_WAITREQUEST_EN
      test_stall();
`endif
      test_spurious();
      test_reset_flight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end
endmodule

// File: doc/avalon_master_bridge.md
# avalon_master_bridge

Avalon-MM initiator that turns a simple valid/ready command stream into single-word Avalon read and write transfers toward peripheral register slaves. It collects returned read data in an in-order response FIFO. It sits between an internal controller (sequencer, DMA, or test driver) and the register adapter side of a peripheral. Read issue is credit-limited, so responses can never overflow.

## Interface
- ADDRESSWIDTH, 4, width of command and Avalon word address
- MAXPENDING, 4, max reads issued but not yet popped from the response port; power of two, ≥2
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDRESSWIDTH  word address
- cmd_data  in  32  write data (ignored for reads)
- rsp_valid  out  1  read response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  32  read data, in issue order
- read  out  1  Avalon read
- write  out  1  Avalon write
- address  out  ADDRESSWIDTH  Avalon address
- data_out  out  32  Avalon writedata
- waitrequest  in  1  Avalon stall (see Configuration)
- read_valid  in  1  Avalon readdatavalid
- data_in  in  32  Avalon readdata
- protocol_error  out  1  sticky: read_valid received with no read outstanding

## Operation
- All Avalon outputs are registered. Only one of read and write is high at a time.
- Command acceptance:
  - A transfer "completes" in any cycle where read or write is high and waitrequest is low.
  - cmd_ready = (bus idle or current transfer completes this cycle) && (credits < MAXPENDING).
  - cmd_ready does not depend on cmd_write. Writes are also blocked when credits are exhausted, which keeps ordering simple.
- On acceptance, read/write, address, and data_out load from the command on the next edge.
  - With no new acceptance, read and write clear once the current transfer completes.
- Credit counter, width $clog2(MAXPENDING)+1:
  - +1 on acceptance of a read command.
  - −1 on rsp handshake.
  - Both in the same cycle: unchanged.
- Outstanding counter:
  - +1 when a read completes on the bus.
  - −1 on read_valid.
- Response FIFO:
  - Depth MAXPENDING. Pushes data_in when read_valid && outstanding ≠ 0.
  - Overflow is impossible by construction.
  - rsp_valid = FIFO not empty. rsp_data = head entry.
  - Push and pop in the same cycle are both performed.
- read_valid with outstanding = 0: data is dropped, protocol_error is set, and it stays set until reset.
- Reset mid-operation drops all in-flight reads and buffered responses. Read data arriving after reset sets protocol_error.
- Reset values: cmd_ready 0 during reset, rsp_valid 0, rsp_data 0, read 0, write 0, address 0, data_out 0, protocol_error 0. Credits, outstanding, and FIFO pointers are 0.

## Timing
- Command accepted in cycle N: read/write high in N+1. Without a stall, the transfer lasts exactly one cycle.
- Back-to-back commands sustain 1 transfer per cycle while credits are available.
- Slave with fixed read latency L (read_valid in cycle N+1+L): rsp_valid high in N+2+L.
- Responses are delivered strictly in issue order. Throughput is 1 response per cycle.
- With MAXPENDING credits held, cmd_ready goes low. It returns high in the cycle after the next rsp handshake.

## Configuration
- AVALON_MASTER_WAITREQUEST_EN defined:
  - waitrequest is honored.
  - read, write, address, and data_out are held stable while waitrequest is high.
  - cmd_ready is low while a stalled transfer is pending.
- Not defined:
  - waitrequest is ignored and treated as 0.
  - Every transfer completes in its single bus cycle. This matches slaves that never stall.

## Test plan
- Write then read: write 0xA5A5_0001 to address 3, then read address 3 from an L=2 model slave.
  - Required: write high 1 cycle with address=3 and data_out=0xA5A5_0001.
  - Required: rsp_data=0xA5A5_0001 with rsp_valid 4 cycles after read acceptance.
- Credit exhaustion: rsp_ready=0, issue 6 reads with MAXPENDING=4.
  - Required: exactly 4 accepted and cmd_ready low.
  - Then pulse rsp_ready for one cycle: 1 more read accepted, responses in address order.
- Streaming: 16 reads to addresses 0..15 with rsp_ready=1 and L=1.
  - Required: one read per cycle with no bubbles.
  - Required: rsp_data sequence equals the slave contents for 0..15.
- Stall (macro defined): waitrequest high 3 cycles on a write to address 7.
  - Required: address and data_out stable for 4 cycles and cmd_ready low throughout.
  - Required: the next command is issued the cycle after completion.
- Spurious data: read_valid with data 0x1234 and no read outstanding.
  - Required: protocol_error=1 and sticky, rsp_valid stays 0.
- Reset mid-flight: assert reset with 2 reads outstanding and 1 response buffered.
  - Required: all outputs at reset values immediately.
  - Required: late read_valid sets protocol_error, rsp_valid stays 0.
